// File: rtl/waitstate_mem_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | waitstate_mem_model : word RAM behind a request/ready bus with GBA-style |
// | sequential/non-sequential wait states, opcode injection and a backdoor.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module waitstate_mem_model #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_NONSEQ = 3,
    parameter int WAIT_SEQ    = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [31:0]                    bus_addr,
    input  logic [31:0]                    bus_wdata,
    input  logic [1:0]                     bus_size,
    input  logic                           bus_read_en,
    input  logic                           bus_write_en,
    output logic [31:0]                    bus_rdata,
    output logic                           bus_ready,
    output logic                           bus_err,
    input  logic                           op_en,
    input  logic [31:0]                    op_addr,
    input  logic [31:0]                    op_data,
    input  logic                           bd_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] bd_addr,
    input  logic [31:0]                    bd_wdata,
    output logic [31:0]                    bd_rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        commit;

    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_write;
    logic        lat_conflict;
    logic        err_pend;

    logic [31:0] prev_addr;
    logic        prev_write;
    logic        seq_valid;

    logic        is_seq;
    logic [3:0]  wait_load;
    logic [AW-1:0] idx;
    logic        out_of_range;
    logic        op_hit;
    logic [31:0] mem_word;
    logic [63:0] dbl_word;
    logic [31:0] rot_word;
    logic [31:0] rd_data;
    logic [3:0]  strobe;

    logic [31:0] mem [DEPTH_WORDS];

    // A request with both enables set still counts as a write for classification.
    assign is_seq    = seq_valid && (prev_write == bus_write_en) &&
                       (bus_addr == prev_addr + 32'd4);
    assign wait_load = is_seq ? 4'(WAIT_SEQ) : 4'(WAIT_NONSEQ);

    assign idx          = lat_addr[AW+1:2];
    assign out_of_range = |lat_addr[31:AW+2];
    assign op_hit       = op_en && (lat_addr == op_addr) && !lat_write;
    assign mem_word     = mem[idx];
    assign dbl_word     = {mem_word, mem_word};
    assign rot_word     = dbl_word[{lat_addr[1:0], 3'b000} +: 32];
    assign bd_rdata     = mem[bd_addr];

    always_comb begin
        rd_data = rot_word;
        strobe  = 4'hF;
        if (op_hit) begin
            rd_data = op_data;
        end else if (out_of_range) begin
            rd_data = lat_addr;
        end else begin
            case (lat_size)
                2'b00:   rd_data = {24'd0, rot_word[7:0]};
                2'b01:   rd_data = {16'd0, lat_addr[1] ? mem_word[31:16] : mem_word[15:0]};
                default: rd_data = rot_word;
            endcase
        end
        case (lat_size)
            2'b00:   strobe = 4'b0001 << lat_addr[1:0];
            2'b01:   strobe = lat_addr[1] ? 4'b1100 : 4'b0011;
            default: strobe = 4'hF;
        endcase
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus_read_en || bus_write_en) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    commit     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= 4'd0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_size     <= 2'd0;
            lat_write    <= 1'b0;
            lat_conflict <= 1'b0;
            err_pend     <= 1'b0;
            prev_addr    <= 32'd0;
            prev_write   <= 1'b0;
            seq_valid    <= 1'b0;
            bus_rdata    <= 32'd0;
            bus_ready    <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            bus_ready <= (state == ST_DONE);
            bus_err   <= (state == ST_DONE) && err_pend;
            if (accept) begin
                cnt          <= wait_load;
                lat_addr     <= bus_addr;
                lat_wdata    <= bus_wdata;
                lat_size     <= bus_size;
                lat_write    <= bus_write_en;
                lat_conflict <= bus_read_en && bus_write_en;
                prev_addr    <= bus_addr;
                prev_write   <= bus_write_en;
                seq_valid    <= 1'b1;
            end
            if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_pend <= lat_conflict || (out_of_range && !op_hit);
                if (!lat_write) begin
                    bus_rdata <= rd_data;
                end
            end
        end
    end

    // Bus commit is applied after the backdoor so it wins on a same-word collision.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (commit && lat_write && !out_of_range) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) begin
                    mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_waitstate_mem_model.sv
`default_nettype none
// Bench for waitstate_mem_model: behavioural memory/latency model, per-cycle
// output comparison, directed literal scenarios and a randomized access phase.
module tb_waitstate_mem_model;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int WN    = 3;
    localparam int WS    = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   bus_addr, bus_wdata, op_addr, op_data, bd_wdata;
    logic [1:0]    bus_size;
    logic          bus_read_en, bus_write_en, op_en, bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bus_rdata, bd_rdata;
    logic          bus_ready, bus_err;

    waitstate_mem_model #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_NONSEQ(WN),
        .WAIT_SEQ   (WS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_size    (bus_size),
        .bus_read_en (bus_read_en),
        .bus_write_en(bus_write_en),
        .bus_rdata   (bus_rdata),
        .bus_ready   (bus_ready),
        .bus_err     (bus_err),
        .op_en       (op_en),
        .op_addr     (op_addr),
        .op_data     (op_data),
        .bd_we       (bd_we),
        .bd_addr     (bd_addr),
        .bd_wdata    (bd_wdata),
        .bd_rdata    (bd_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int          cyc;
        logic        rd;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t eq[$];

    logic [31:0] mdl [DEPTH];
    logic        m_seq_valid;
    logic [31:0] m_prev_addr;
    logic        m_prev_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: what the access must produce, from the access rules alone.
    task automatic model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic rd, input logic wr,
                                output exp_t e);
        logic        seq, oor, hit, sel;
        logic [31:0] m, r;
        int          w, s, wi;
        seq = m_seq_valid && (m_prev_wr == wr) && (addr == m_prev_addr + 32'd4);
        w   = seq ? WS : WN;
        m_seq_valid = 1'b1;
        m_prev_addr = addr;
        m_prev_wr   = wr;
        oor = (addr >> (AW + 2)) != 0;
        hit = op_en && (addr == op_addr) && !wr;
        wi  = (addr / 4) % DEPTH;
        m   = mdl[wi];
        s   = 8 * (addr % 4);
        if (hit)            r = op_data;
        else if (oor)       r = addr;
        else if (size == 0) r = (m >> s) & 32'hFF;
        else if (size == 1) r = (m >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        else                r = (m >> s) | (m << (32 - s));
        if (wr && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (size == 0)      sel = (i == addr % 4);
                else if (size == 1) sel = (i / 2 == (addr / 2) % 2);
                else                sel = 1'b1;
                if (sel) m[8*i +: 8] = wdata[8*i +: 8];
            end
            mdl[wi] = m;
        end
        e.cyc   = cyc + 1 + w + 2;
        e.rd    = !wr;
        e.err   = (rd && wr) || (oor && !hit);
        e.rdata = r;
    endtask

    // Called on a falling edge; returns on the falling edge where ready was seen.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic rd, input logic wr,
                             output logic [31:0] got, output logic gerr, output int lat);
        exp_t e;
        int   a_cyc;
        bit   done;
        bus_addr     = addr;
        bus_wdata    = wdata;
        bus_size     = size;
        bus_read_en  = rd;
        bus_write_en = wr;
        a_cyc = cyc + 1;
        model_access(addr, wdata, size, rd, wr, e);
        eq.push_back(e);
        lat = -1; got = 32'd0; gerr = 1'b0; done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (bus_ready) begin
                lat  = cyc - a_cyc;
                got  = bus_rdata;
                gerr = bus_err;
                done = 1'b1;
            end
        end
        bus_read_en  = 1'b0;
        bus_write_en = 1'b0;
        if (!done) check("ready_timeout", {31'd0, bus_ready}, 32'd1);
    endtask

    task automatic bd_write(input int a, input logic [31:0] d);
        bd_we    = 1'b1;
        bd_addr  = AW'(a);
        bd_wdata = d;
        mdl[a]   = d;
        @(negedge clk);
        bd_we    = 1'b0;
    endtask

    task automatic bd_check(input string name, input int a, input logic [31:0] exp);
        bd_addr = AW'(a);
        #1;
        check(name, bd_rdata, exp);
    endtask

    // Per-cycle comparison of bus outputs against the expected completion queue.
    always @(negedge clk) begin
        if (chk_en) begin
            logic er;
            er = (eq.size() > 0) && (eq[0].cyc == cyc);
            check("ready", {31'd0, bus_ready}, {31'd0, er});
            check("err", {31'd0, bus_err}, {31'd0, er && eq[0].err});
            if (er && eq[0].rd) check("rdata", bus_rdata, eq[0].rdata);
            if (er) void'(eq.pop_front());
            else if (eq.size() > 0 && eq[0].cyc < cyc) void'(eq.pop_front());
        end
    end

    initial begin
        logic [31:0] got, last_addr, addr, wdata;
        logic        gerr, rd, wr;
        logic [1:0]  size;
        int          lat, pick;

        reset_n = 1'b0;
        bus_addr = 0; bus_wdata = 0; bus_size = 0; bus_read_en = 0; bus_write_en = 0;
        op_en = 0; op_addr = 0; op_data = 0; bd_we = 0; bd_addr = '0; bd_wdata = 0;
        m_seq_valid = 1'b0; m_prev_addr = 0; m_prev_wr = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus_ready}, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        for (int i = 0; i < 64; i++) bd_write(i, $urandom());

        // Scenario 1: non-sequential word read
        bd_write(4, 32'hAABBCCDD);
        do_access(32'h10, 0, 2'b10, 1, 0, got, gerr, lat);
        check("s1_rdata", got, 32'hAABBCCDD);
        check("s1_lat", lat, 5);
        check("s1_err", {31'd0, gerr}, 32'd0);

        // Scenario 2: sequential then non-sequential
        do_access(32'h10, 0, 2'b10, 1, 0, got, gerr, lat);
        do_access(32'h14, 0, 2'b10, 1, 0, got, gerr, lat);
        check("s2_seq_lat", lat, 3);
        do_access(32'h20, 0, 2'b10, 1, 0, got, gerr, lat);
        check("s2_nonseq_lat", lat, 5);

        // Scenario 3: byte write and half read
        do_access(32'h11, 32'h0000EE00, 2'b00, 0, 1, got, gerr, lat);
        bd_check("s3_bd", 4, 32'hAABBEEDD);
        do_access(32'h12, 0, 2'b01, 1, 0, got, gerr, lat);
        check("s3_half", got, 32'h0000AABB);

        // Scenario 4: rotated word read and opcode injection
        bd_write(4, 32'h11223344);
        do_access(32'h11, 0, 2'b10, 1, 0, got, gerr, lat);
        check("s4_rot", got, 32'h44112233);
        op_en = 1; op_addr = 32'h11; op_data = 32'hE3A00001;
        do_access(32'h11, 0, 2'b10, 1, 0, got, gerr, lat);
        check("s4_op", got, 32'hE3A00001);
        op_en = 0;

        // Scenario 5: out-of-range read and write
        bd_write(0, 32'h12345678);
        do_access(32'h0001_0000, 0, 2'b10, 1, 0, got, gerr, lat);
        check("s5_rdata", got, 32'h0001_0000);
        check("s5_rd_err", {31'd0, gerr}, 32'd1);
        do_access(32'h0001_0000, 32'hFFFFFFFF, 2'b10, 0, 1, got, gerr, lat);
        check("s5_wr_err", {31'd0, gerr}, 32'd1);
        bd_check("s5_bd", 0, 32'h12345678);

        // Scenario 5b: both enables -> write plus error
        do_access(32'h40, 32'hA5A5A5A5, 2'b10, 1, 1, got, gerr, lat);
        check("s5b_err", {31'd0, gerr}, 32'd1);
        bd_check("s5b_bd", 16, 32'hA5A5A5A5);

        // Scenario 6: reset during the wait phase of a write
        bus_addr = 32'h10; bus_wdata = 32'h55555555; bus_size = 2'b10;
        bus_write_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        bus_write_en = 1'b0;
        eq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_seq_valid = 1'b0;
        repeat (8) @(negedge clk);
        bd_check("s6_bd", 4, 32'h11223344);
        @(negedge clk);
        do_access(32'h14, 32'hCAFEF00D, 2'b10, 0, 1, got, gerr, lat);
        check("s6_post_lat", lat, 5);

        // Randomized accesses
        last_addr = 32'h14;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                pick = $urandom_range(0, 63);
                bd_write(pick, $urandom());
                bd_check("rnd_bd", pick, mdl[pick]);
            end
            pick = $urandom_range(0, 99);
            if (pick < 40 && last_addr < 32'd252) addr = last_addr + 32'd4;
            else if (pick < 50)                   addr = $urandom() | 32'h0000_1000;
            else                                  addr = $urandom_range(0, 255);
            size  = 2'($urandom_range(0, 3));
            wdata = $urandom();
            pick  = $urandom_range(0, 99);
            rd    = (pick < 55);
            wr    = (pick >= 45);
            op_en   = ($urandom_range(0, 6) == 0);
            op_addr = ($urandom_range(0, 1) == 0) ? addr : $urandom_range(0, 255);
            op_data = $urandom();
            do_access(addr, wdata, size, rd, wr, got, gerr, lat);
            op_en = 0;
            last_addr = addr;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        for (int i = 0; i < 64; i++) bd_check("sweep_bd", i, mdl[i]);
        repeat (3) @(negedge clk);
        check("queue_drained", eq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
